// File: rtl/sd_controller_arbiter_if.sv
// rtl/sd_controller_arbiter_if.sv - requester and controller signal bundle for sd_controller_arbiter
interface sd_controller_arbiter_if;
    logic [1:0]    req_rd_en;
    logic [1:0]    req_wr_en;
    logic [31:0]   req0_addr;
    logic [31:0]   req1_addr;
    logic [4095:0] req0_write_data;
    logic [4095:0] req1_write_data;
    logic [1:0]    ack;
    logic [1:0]    err;
    logic [4095:0] read_data;
    logic          sd_rd_en;
    logic          sd_wr_en;
    logic [31:0]   sd_addr;
    logic [4095:0] sd_write_data;
    logic [4095:0] sd_read_data;
    logic          sd_busy;
    logic [2:0]    arb_state;
    logic          grant;

    // Arbiter view
    modport slave (
        input  req_rd_en, req_wr_en, req0_addr, req1_addr,
        input  req0_write_data, req1_write_data, sd_read_data, sd_busy,
        output ack, err, read_data, sd_rd_en, sd_wr_en, sd_addr,
        output sd_write_data, arb_state, grant
    );

    // Requester/controller view
    modport master (
        output req_rd_en, req_wr_en, req0_addr, req1_addr,
        output req0_write_data, req1_write_data, sd_read_data, sd_busy,
        input  ack, err, read_data, sd_rd_en, sd_wr_en, sd_addr,
        input  sd_write_data, arb_state, grant
    );
endinterface

// File: rtl/sd_controller_arbiter.sv
// rtl/sd_controller_arbiter.sv - two-port arbiter in front of sd_controller (option macro: SD_ARB_ROUND_ROBIN_EN)
module sd_controller_arbiter #(
    parameter int START_TIMEOUT = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    sd_controller_arbiter_if.slave  sd_if
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        WAIT_END   = 3'd3,
        DONE       = 3'd4
    } state_t;

    localparam int CW = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LOAD = CW'(START_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          op_rd_q, op_rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ack_q, ack_d;
    logic [1:0]    mask_q, mask_d;
    logic [1:0]    err_c;
    logic          sd_rd_en_c;
    logic          sd_wr_en_c;
    logic [1:0]    eligible;
    logic          winner;
    logic          winner_rd;
`ifdef SD_ARB_ROUND_ROBIN_EN
    logic          rr_ptr_q, rr_ptr_d;
`endif

    assign eligible = (sd_if.req_rd_en | sd_if.req_wr_en) & ~mask_q;

    // Pick the requester to serve: on a tie the one not served last, otherwise whoever asks
`ifdef SD_ARB_ROUND_ROBIN_EN
    always_comb begin
        winner = 1'b0;
        if (eligible == 2'b11) begin
            winner = ~rr_ptr_q;
        end else if (eligible[1]) begin
            winner = 1'b1;
        end
    end
`else
    // Pick the requester to serve: requester 0 always wins a tie
    always_comb begin
        winner = 1'b0;
        if (!eligible[0] && eligible[1]) begin
            winner = 1'b1;
        end
    end
`endif

    // A requester asking for both operations gets the read
    assign winner_rd = winner ? sd_if.req_rd_en[1] : sd_if.req_rd_en[0];

    // Next-state and pulse generation for the grant/issue/handshake sequence
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        op_rd_d    = op_rd_q;
        cnt_d      = cnt_q;
        ack_d      = 2'b00;
        mask_d     = 2'b00;
        err_c      = 2'b00;
        sd_rd_en_c = 1'b0;
        sd_wr_en_c = 1'b0;
`ifdef SD_ARB_ROUND_ROBIN_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                // Busy while idle means the controller is still initialising the card
                if (!sd_if.sd_busy && (eligible != 2'b00)) begin
                    grant_d = winner;
                    op_rd_d = winner_rd;
`ifdef SD_ARB_ROUND_ROBIN_EN
                    rr_ptr_d = winner;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                sd_rd_en_c = op_rd_q;
                sd_wr_en_c = ~op_rd_q;
                cnt_d      = TO_LOAD;
                state_d    = WAIT_START;
            end
            WAIT_START: begin
                if (sd_if.sd_busy) begin
                    state_d = WAIT_END;
                end else if (cnt_q == '0) begin
                    err_c[grant_q]  = 1'b1;
                    mask_d[grant_q] = 1'b1;
                    state_d         = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_END: begin
                if (!sd_if.sd_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ack_d[grant_q]  = 1'b1;
                mask_d[grant_q] = 1'b1;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant and handshake registers; reset aborts any transaction in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            op_rd_q <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= 2'b00;
            mask_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            op_rd_q <= op_rd_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            mask_q  <= mask_d;
        end
    end

`ifdef SD_ARB_ROUND_ROBIN_EN
    // Last-served pointer; starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= 1'b1;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign sd_if.sd_rd_en      = sd_rd_en_c;
    assign sd_if.sd_wr_en      = sd_wr_en_c;
    assign sd_if.ack           = ack_q;
    assign sd_if.err           = err_c;
    assign sd_if.grant         = grant_q;
    assign sd_if.arb_state     = state_q;
    assign sd_if.sd_addr       = grant_q ? sd_if.req1_addr : sd_if.req0_addr;
    assign sd_if.sd_write_data = grant_q ? sd_if.req1_write_data : sd_if.req0_write_data;
    assign sd_if.read_data     = sd_if.sd_read_data;

endmodule

// File: tb/tb_sd_controller_arbiter.sv
// tb/tb_sd_controller_arbiter.sv - scoreboard bench for sd_controller_arbiter
module tb_sd_controller_arbiter;

    localparam int TO = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    sd_controller_arbiter_if bus();

    sd_controller_arbiter #(.START_TIMEOUT(TO)) dut (
        .clock (clock),
        .reset (reset),
        .sd_if (bus)
    );

    logic          model_busy = 1'b0;
    logic          force_busy = 1'b0;
    logic [4095:0] model_rdata = '0;
    int            model_delay = 3;
    int            model_hold = 20;

    assign bus.sd_busy      = model_busy | force_busy;
    assign bus.sd_read_data = model_rdata;

    typedef struct {
        int            port;
        bit            rd;
        logic [31:0]   addr;
        logic [4095:0] wdata;
    } iss_t;

    typedef struct {
        int            port;
        bit            is_err;
        bit            rd;
        logic [4095:0] rdata;
    } done_t;

    iss_t  iss_q[$];
    done_t done_q[$];
    int    n_issue = 0;
    int    en_cyc = 0;
    int    fall_cyc = 0;
    int    done_cyc = 0;

    function automatic logic [4095:0] rand_blk();
        logic [4095:0] b;
        for (int i = 0; i < 128; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Controller model: checks each issued command against the scoreboard, then plays busy
    initial begin : ctrl_model
        iss_t e;
        forever begin
            @(negedge clock);
            if (reset && (bus.sd_rd_en || bus.sd_wr_en)) begin
                n_issue++;
                en_cyc = cyc;
                checks++;
                if (iss_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue_stray: rd_en=%0b wr_en=%0b grant=%0d, expected no command", bus.sd_rd_en, bus.sd_wr_en, bus.grant);
                end else begin
                    e = iss_q.pop_front();
                    if ({bus.sd_rd_en, bus.sd_wr_en} !== {e.rd, ~e.rd} || bus.grant !== 1'(e.port) || bus.sd_addr !== e.addr) begin
                        errors++;
                        $display("FAIL issue_cmd: rd/wr=%b%b grant=%0d addr=%h, expected rd/wr=%b%b grant=%0d addr=%h",
                                 bus.sd_rd_en, bus.sd_wr_en, bus.grant, bus.sd_addr, e.rd, ~e.rd, e.port, e.addr);
                    end
                    if (!e.rd) begin
                        checks++;
                        if (bus.sd_write_data !== e.wdata) begin
                            errors++;
                            $display("FAIL issue_wdata: sd_write_data[31:0]=%h, expected %h", bus.sd_write_data[31:0], e.wdata[31:0]);
                        end
                    end
                end
                if (model_delay >= 0) begin
                    for (int k = 0; k < model_delay && reset; k++) @(negedge clock);
                    if (reset) begin
                        model_busy = 1'b1;
                        for (int k = 0; k < model_hold && reset; k++) @(negedge clock);
                        model_busy = 1'b0;
                        fall_cyc = cyc;
                    end
                end
            end
        end
    end

    // Completion monitor: every ack/err pulse must match the next scoreboard entry
    initial begin : done_mon
        done_t      d;
        logic [1:0] ea;
        logic [1:0] ee;
        forever begin
            @(negedge clock);
            if (bus.ack !== 2'b00 || bus.err !== 2'b00) begin
                done_cyc = cyc;
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_stray: ack=%b err=%b, expected none", bus.ack, bus.err);
                end else begin
                    d  = done_q.pop_front();
                    ea = d.is_err ? 2'b00 : 2'(1 << d.port);
                    ee = d.is_err ? 2'(1 << d.port) : 2'b00;
                    if (bus.ack !== ea || bus.err !== ee) begin
                        errors++;
                        $display("FAIL done_resp: ack=%b err=%b, expected ack=%b err=%b", bus.ack, bus.err, ea, ee);
                    end
                    if (!d.is_err && d.rd) begin
                        checks++;
                        if (bus.read_data !== d.rdata) begin
                            errors++;
                            $display("FAIL read_data: read_data[31:0]=%h, expected %h", bus.read_data[31:0], d.rdata[31:0]);
                        end
                    end
                end
            end
        end
    end

    // Requester behaviour while waiting: drop a request once its ack/err is seen
    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                if (bus.ack[i] || bus.err[i]) begin
                    bus.req_rd_en[i] = 1'b0;
                    bus.req_wr_en[i] = 1'b0;
                end
            end
            if (done_q.size() == 0 && iss_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({bus.sd_rd_en, bus.sd_wr_en, bus.ack, bus.err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_pulses: rd/wr/ack/err=%b, expected 000000", {bus.sd_rd_en, bus.sd_wr_en, bus.ack, bus.err});
        end
        checks++;
        if (bus.grant !== 1'b0 || bus.arb_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: grant=%0d state=%0d, expected 0 0", bus.grant, bus.arb_state);
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.arb_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: state=%0d, expected 0", bus.arb_state);
        end
    endtask

    task automatic test_single_read();
        bit ok;
        int base;
        int req_cyc;
        model_delay = 3;
        model_hold  = 20;
        model_rdata = rand_blk();
        repeat (2) @(negedge clock);
        base    = n_issue;
        req_cyc = cyc;
        bus.req0_addr = 32'h10;
        bus.req_rd_en = 2'b01;
        iss_q.push_back('{port: 0, rd: 1'b1, addr: 32'h10, wdata: '0});
        done_q.push_back('{port: 0, is_err: 1'b0, rd: 1'b1, rdata: model_rdata});
        wait_done(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_read_done: completed=0, expected 1");
        end
        checks++;
        if (n_issue - base != 1) begin
            errors++;
            $display("FAIL single_read_pulses: %0d pulses, expected 1", n_issue - base);
        end
        checks++;
        if (en_cyc - req_cyc != 1) begin
            errors++;
            $display("FAIL single_read_latency: %0d cycles, expected 1", en_cyc - req_cyc);
        end
        checks++;
        if (done_cyc - fall_cyc != 2) begin
            errors++;
            $display("FAIL single_read_ack_delay: %0d cycles, expected 2", done_cyc - fall_cyc);
        end
    endtask

    task automatic test_priority();
        bit            ok;
        int            p;
        int            w;
        logic [31:0]   a0, a1;
        logic [4095:0] d0, d1;
        model_delay = 2;
        model_hold  = 4;
        for (int r = 0; r < 4; r++) begin
            p = r % 2;
            repeat (2) @(negedge clock);
            a0 = $urandom; a1 = $urandom;
            d0 = rand_blk(); d1 = rand_blk();
            bus.req0_addr = a0; bus.req0_write_data = d0;
            bus.req1_addr = a1; bus.req1_write_data = d1;
            iss_q.push_back('{port: p, rd: 1'b0, addr: (p == 0) ? a0 : a1, wdata: (p == 0) ? d0 : d1});
            done_q.push_back('{port: p, is_err: 1'b0, rd: 1'b0, rdata: '0});
            bus.req_wr_en[p] = 1'b1;
            wait_done(60, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL solo_done: round %0d completed=0, expected 1", r);
            end
            repeat (2) @(negedge clock);
`ifdef SD_ARB_ROUND_ROBIN_EN
            w = 1 - p;
`else
            w = 0;
`endif
            a0 = $urandom; a1 = $urandom;
            d0 = rand_blk(); d1 = rand_blk();
            bus.req0_addr = a0; bus.req0_write_data = d0;
            bus.req1_addr = a1; bus.req1_write_data = d1;
            iss_q.push_back('{port: w, rd: 1'b0, addr: (w == 0) ? a0 : a1, wdata: (w == 0) ? d0 : d1});
            iss_q.push_back('{port: 1 - w, rd: 1'b0, addr: (w == 0) ? a1 : a0, wdata: (w == 0) ? d1 : d0});
            done_q.push_back('{port: w, is_err: 1'b0, rd: 1'b0, rdata: '0});
            done_q.push_back('{port: 1 - w, is_err: 1'b0, rd: 1'b0, rdata: '0});
            bus.req_wr_en = 2'b11;
            wait_done(120, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL tie_done: round %0d completed=0, expected 1", r);
            end
        end
    endtask

    task automatic test_both_ops();
        bit ok;
        model_delay = 1;
        model_hold  = 3;
        model_rdata = rand_blk();
        repeat (2) @(negedge clock);
        bus.req1_addr = 32'h0000_0abc;
        bus.req1_write_data = rand_blk();
        bus.req_rd_en = 2'b10;
        bus.req_wr_en = 2'b10;
        iss_q.push_back('{port: 1, rd: 1'b1, addr: 32'h0000_0abc, wdata: '0});
        done_q.push_back('{port: 1, is_err: 1'b0, rd: 1'b1, rdata: model_rdata});
        wait_done(60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL both_ops_done: completed=0, expected 1");
        end
    endtask

    task automatic test_timeout();
        bit ok;
        model_delay = -1;
        repeat (2) @(negedge clock);
        bus.req0_addr = 32'h0000_5000;
        bus.req0_write_data = rand_blk();
        bus.req_wr_en = 2'b01;
        iss_q.push_back('{port: 0, rd: 1'b0, addr: 32'h0000_5000, wdata: bus.req0_write_data});
        done_q.push_back('{port: 0, is_err: 1'b1, rd: 1'b0, rdata: '0});
        wait_done(60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_done: completed=0, expected 1");
        end
        checks++;
        if (done_cyc - en_cyc != TO) begin
            errors++;
            $display("FAIL timeout_delay: %0d cycles, expected %0d", done_cyc - en_cyc, TO);
        end
        @(negedge clock);
        checks++;
        if (bus.arb_state !== 3'd0) begin
            errors++;
            $display("FAIL timeout_idle: state=%0d, expected 0", bus.arb_state);
        end
        model_delay = 3;
    endtask

    task automatic test_init_gating();
        bit ok;
        int base;
        int fcyc;
        model_delay = 3;
        model_hold  = 5;
        model_rdata = rand_blk();
        @(negedge clock);
        reset = 1'b0;
        force_busy = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        base = n_issue;
        bus.req1_addr = 32'h2000_0040;
        bus.req_rd_en = 2'b10;
        iss_q.push_back('{port: 1, rd: 1'b1, addr: 32'h2000_0040, wdata: '0});
        done_q.push_back('{port: 1, is_err: 1'b0, rd: 1'b1, rdata: model_rdata});
        repeat (100) @(negedge clock);
        checks++;
        if (n_issue != base) begin
            errors++;
            $display("FAIL init_gate_hold: %0d pulses while busy, expected 0", n_issue - base);
        end
        force_busy = 1'b0;
        fcyc = cyc;
        wait_done(60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL init_gate_done: completed=0, expected 1");
        end
        checks++;
        if (en_cyc - fcyc != 1) begin
            errors++;
            $display("FAIL init_gate_latency: %0d cycles, expected 1", en_cyc - fcyc);
        end
    endtask

    task automatic test_reset_midop();
        bit reached;
        int base;
        model_delay = 3;
        model_hold  = 50;
        repeat (2) @(negedge clock);
        bus.req1_addr = 32'h0000_7700;
        bus.req1_write_data = rand_blk();
        bus.req_wr_en = 2'b10;
        iss_q.push_back('{port: 1, rd: 1'b0, addr: 32'h0000_7700, wdata: bus.req1_write_data});
        done_q.push_back('{port: 1, is_err: 1'b0, rd: 1'b0, rdata: '0});
        reached = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (bus.arb_state === 3'd3) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL midop_wait_end: state=%0d, expected 3", bus.arb_state);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.sd_rd_en, bus.sd_wr_en, bus.ack, bus.err} !== 6'b0 || bus.grant !== 1'b0 || bus.arb_state !== 3'd0) begin
            errors++;
            $display("FAIL midop_reset: pulses=%b grant=%0d state=%0d, expected 000000 0 0",
                     {bus.sd_rd_en, bus.sd_wr_en, bus.ack, bus.err}, bus.grant, bus.arb_state);
        end
        done_q.delete();
        iss_q.delete();
        bus.req_wr_en = 2'b00;
        bus.req_rd_en = 2'b00;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        base = n_issue;
        repeat (60) @(negedge clock);
        checks++;
        if (n_issue != base || bus.arb_state !== 3'd0) begin
            errors++;
            $display("FAIL midop_after: %0d pulses state=%0d, expected 0 0", n_issue - base, bus.arb_state);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bus.req_rd_en = 2'b00;
        bus.req_wr_en = 2'b00;
        bus.req0_addr = '0;
        bus.req1_addr = '0;
        bus.req0_write_data = '0;
        bus.req1_write_data = '0;
        test_reset();
        test_single_read();
        test_priority();
        test_both_ops();
        test_timeout();
        test_init_gating();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
